seq_divider_ctrl: RTL and testbench

- Multi-cycle unsigned 8-bit restoring divider.
- Sequences one shared adder_subtractor instance (M=1, subtract mode) through 8 trial-subtract iterations, one per clock.
- Sits beside the combinational arithmetic blocks as the first sequenced user of the adder_subtractor datapath.
- Start/done handshake; results held stable until the next accepted start.

---
 rtl/seq_divider_ctrl_pkg.sv | 22 ++
 rtl/seq_divider_ctrl_adder_subtractor.sv | 27 ++
 rtl/seq_divider_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_divider_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_ctrl_pkg.sv
// Shared types and constants for the sequenced restoring divider.
// Holds the controller state encoding, iteration count and divide-by-zero quotient.
package seq_divider_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DATA_W     = 8;
  localparam int ITER_COUNT = 8;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [DATA_W-1:0] DIVZ_Q_DEFAULT = 8'hFF;

  // True on the final trial-subtract iteration of an operation.
  function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(ITER_COUNT - 1);
  endfunction

endpackage

// File: rtl/seq_divider_ctrl_adder_subtractor.sv
// Ripple-style W-bit adder/subtractor: m=0 adds, m=1 computes a - b as a + ~b + 1.
// In subtract mode cout=1 means no borrow, i.e. a >= b as unsigned values.
module seq_divider_ctrl_adder_subtractor
  import seq_divider_ctrl_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  logic [W-1:0] b_eff;
  logic [W:0]   total;

  always_comb begin
    b_eff    = b ^ {W{m}};
    total    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, m};
    sum      = total[W-1:0];
    cout     = total[W];
    overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  end

endmodule

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned 8-bit restoring divider: one trial subtraction per clock
// through a shared adder/subtractor, with start/done handshake and held results.
module seq_divider_ctrl
  import seq_divider_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] DIVZ_Q = DIVZ_Q_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  // Handshake: start is only sampled in IDLE; a sampled start is accepted at that
  // edge. busy is high for the 8 CALC cycles, done pulses for one cycle after, and
  // quotient/remainder/div_by_zero stay stable until the next accepted start.

  state_t state, state_next;

  logic [DATA_W-1:0] r_reg, q_reg, d_reg;
  logic [CNT_W-1:0]  cnt;

  logic load, divz_load, iter;

  logic              carry_bit, take;
  logic [DATA_W-1:0] shifted, diff;
  logic [DATA_W-1:0] r_next, q_next;
  logic              sub_cout;
  logic              ovf_unused;

  seq_divider_ctrl_adder_subtractor #(
    .W(DATA_W)
  ) u_addsub (
    .a        (shifted),
    .b        (d_reg),
    .m        (1'b1),
    .sum      (diff),
    .cout     (sub_cout),
    .overflow (ovf_unused)
  );

  // A set carry_bit means the 9-bit partial remainder already exceeds D,
  // so the subtraction always succeeds and diff's low 8 bits are exact.
  always_comb begin
    carry_bit = r_reg[DATA_W-1];
    shifted   = {r_reg[DATA_W-2:0], q_reg[DATA_W-1]};
    take      = carry_bit | sub_cout;
    r_next    = take ? diff : shifted;
    q_next    = {q_reg[DATA_W-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    divz_load  = 1'b0;
    iter       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            divz_load  = 1'b1;
            state_next = ST_DONE;
          end else begin
            load       = 1'b1;
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        iter = 1'b1;
        if (last_iter(cnt)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      d_reg       <= divisor;
      q_reg       <= dividend;
      r_reg       <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (divz_load) begin
      quotient    <= DIVZ_Q;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (iter) begin
      r_reg <= r_next;
      q_reg <= q_next;
      cnt   <= cnt + 1'b1;
      if (last_iter(cnt)) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl: directed cases with literal results
// plus randomized operations compared every cycle against a cycle-timed model.
module tb_seq_divider_ctrl;
  import seq_divider_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor  = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the accepted operation by edge number; results are plain / and %.
  int         e         = 0;
  bit         acc_v     = 1'b0;
  bit         acc_dz    = 1'b0;
  int         acc_k     = 0;
  int         res_edge  = 0;
  int         free_edge = 0;
  bit         pend      = 1'b0;
  logic [7:0] m_q       = 8'd0;
  logic [7:0] m_r       = 8'd0;
  bit         m_z       = 1'b0;
  logic [7:0] p_q, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v     = 1'b0;
      pend      = 1'b0;
      free_edge = 0;
      m_q       = 8'd0;
      m_r       = 8'd0;
      m_z       = 1'b0;
    end else begin
      e++;
      if (pend && e == res_edge) begin
        m_q  = p_q;
        m_r  = p_r;
        pend = 1'b0;
      end
      if (start && e >= free_edge) begin
        acc_v = 1'b1;
        acc_k = e;
        if (divisor == 8'd0) begin
          acc_dz    = 1'b1;
          m_q       = 8'hFF;
          m_r       = dividend;
          m_z       = 1'b1;
          free_edge = e + 2;
        end else begin
          acc_dz    = 1'b0;
          m_z       = 1'b0;
          pend      = 1'b1;
          p_q       = dividend / divisor;
          p_r       = dividend % divisor;
          res_edge  = e + ITER_COUNT;
          free_edge = e + ITER_COUNT + 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit exp_busy, exp_done;
    if (rst_n) begin
      exp_busy = acc_v && !acc_dz && (e >= acc_k) && (e <= acc_k + ITER_COUNT - 1);
      exp_done = acc_v && (acc_dz ? (e == acc_k) : (e == acc_k + ITER_COUNT));
      check("cyc_busy", 32'(busy), 32'(exp_busy));
      check("cyc_done", 32'(done), 32'(exp_done));
      check("cyc_quotient", 32'(quotient), 32'(m_q));
      check("cyc_remainder", 32'(remainder), 32'(m_r));
      check("cyc_div_by_zero", 32'(div_by_zero), 32'(m_z));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit noise);
    int n, nb, eq, er;
    bit seen;
    n    = 0;
    nb   = 0;
    seen = 1'b0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      n++;
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      @(negedge clk);
    end
    if (b == 8'd0) begin
      eq = 255;
      er = int'(a);
    end else begin
      eq = int'(a) / int'(b);
      er = int'(a) % int'(b);
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("latency", 32'(n), (b == 8'd0) ? 32'd1 : 32'd9);
    check("busy_cycles", 32'(nb), (b == 8'd0) ? 32'd0 : 32'd8);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), (b == 8'd0) ? 32'd1 : 32'd0);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7, 1'b0);
    check("lit_100_7_q", 32'(quotient), 32'd14);
    check("lit_100_7_r", 32'(remainder), 32'd2);
    do_div(8'd255, 8'd129, 1'b0);
    check("lit_255_129_q", 32'(quotient), 32'd1);
    check("lit_255_129_r", 32'(remainder), 32'd126);
    do_div(8'd255, 8'd1, 1'b0);
    check("lit_255_1_q", 32'(quotient), 32'd255);
    check("lit_255_1_r", 32'(remainder), 32'd0);
    do_div(8'd5, 8'd9, 1'b0);
    check("lit_5_9_q", 32'(quotient), 32'd0);
    check("lit_5_9_r", 32'(remainder), 32'd5);
    do_div(8'd200, 8'd0, 1'b0);
    check("lit_200_0_q", 32'(quotient), 32'd255);
    check("lit_200_0_r", 32'(remainder), 32'd200);
    check("lit_200_0_dbz", 32'(div_by_zero), 32'd1);

    // start pulses during CALC and DONE are ignored
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ign_done_seen", 32'(seen), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_q", 32'(quotient), 32'd14);
    check("ign_r", 32'(remainder), 32'd2);
    check("ign_no_second_done", 32'(done), 32'd0);
    do_div(8'd50, 8'd5, 1'b0);
    check("lit_50_5_q", 32'(quotient), 32'd10);
    check("lit_50_5_r", 32'(remainder), 32'd0);

    // asynchronous reset at CALC cycle 4
    do_div(8'd100, 8'd7, 1'b0);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    do_div(8'd9, 8'd3, 1'b0);
    check("lit_9_3_q", 32'(quotient), 32'd3);
    check("lit_9_3_r", 32'(remainder), 32'd0);

    // results hold while operands wiggle with start low
    do_div(8'd100, 8'd7, 1'b0);
    for (int i = 0; i < 20; i++) begin
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      check("hold_q", 32'(quotient), 32'd14);
      check("hold_r", 32'(remainder), 32'd2);
      check("hold_done", 32'(done), 32'd0);
    end

    // randomized operations with spurious start pulses while busy
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) b = 8'd0;
      else if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(129, 255));
      else b = 8'($urandom_range(1, 255));
      do_div(a, b, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
